// File: rtl/f7_rd_ctrl.sv
// f7_rd_ctrl
// Reads DEPTH features from the f7 RAM after each start pulse and streams
// them out on a valid/ready interface.
//
// Handshake: a beat transfers on a rising edge where m_valid & m_ready are
// both 1. Once m_valid is 1 it stays 1, and m_data/m_last stay stable, until
// that transfer happens. m_ready may change freely and never affects m_valid.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle frame start, accepted only in IDLE
//   f7_rd_en/raddr    RAM read strobe and address
//   f7_rdata          RAM data, valid RD_LAT cycles after f7_rd_en
//   m_valid/m_data/m_last/m_ready   output stream
//   busy              high in READ and DRAIN
//   done              one-cycle pulse after the m_last transfer
//   dbg_state         one-hot FSM state, for observation only
module f7_rd_ctrl #(
  parameter int DEPTH  = 84,
  parameter int DW     = 16,
  parameter int AW     = 7,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          f7_rd_en,
  output logic [AW-1:0] f7_raddr,
  input  logic [DW-1:0] f7_rdata,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          busy,
  output logic          done,
  output logic [3:0]    dbg_state
);

  // FIFO sized so a full pipeline of reads always has a slot waiting.
  localparam int FD = RD_LAT + 2;
  localparam int PW = $clog2(FD);
  localparam int CW = $clog2(FD + 1);
  localparam logic [AW-1:0] LAST_IDX   = AW'(DEPTH - 1);
  localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(FD);
  localparam logic [PW-1:0] PTR_LAST   = PW'(FD - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_READ  = 4'b0010,
    S_DRAIN = 4'b0100,
    S_DONE  = 4'b1000
  } state_t;

  state_t            r_state;
  logic [AW-1:0]     r_addr;
  logic [AW-1:0]     r_idx;       // index of the FIFO head within the frame
  logic [RD_LAT-1:0] r_vsr;       // read-valid pipeline matching RAM latency
  logic [CW-1:0]     r_inflight;
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [DW-1:0]     r_mem [0:FD-1];

  logic              w_rd_en;
  logic              w_push;
  logic              w_pop;
  logic              w_not_empty;
  logic [CW:0]       w_credit_used;

  // Every slot already holding data or promised to an in-flight read is
  // counted, so a read is only issued when its data is guaranteed a slot.
  assign w_credit_used = {1'b0, r_count} + {1'b0, r_inflight};
  assign w_rd_en       = (r_state == S_READ) && (w_credit_used < CREDIT_MAX);
  assign w_push        = r_vsr[RD_LAT-1];
  assign w_not_empty   = (r_count != '0);
  assign w_pop         = w_not_empty && m_ready;

  assign f7_rd_en  = w_rd_en;
  assign f7_raddr  = r_addr;
  assign m_valid   = w_not_empty;
  // Gated so the output is 0 rather than stale storage when nothing is held.
  assign m_data    = w_not_empty ? r_mem[r_rd_ptr] : '0;
  assign m_last    = w_not_empty && (r_idx == LAST_IDX);
  assign busy      = (r_state == S_READ) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);
  assign dbg_state = r_state;

  // FSM, read address and output index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (start) r_state <= S_READ;
        S_READ:  if (w_rd_en && (r_addr == LAST_IDX)) r_state <= S_DRAIN;
        S_DRAIN: if (w_pop && m_last) r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_rd_en) begin
        r_addr <= (r_addr == LAST_IDX) ? '0 : r_addr + 1'b1;
      end

      if (w_pop) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end
    end
  end

  // Latency pipeline, in-flight counter and FIFO control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vsr      <= '0;
      r_inflight <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_vsr[0] <= w_rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vsr[i] <= r_vsr[i-1];
      end

      case ({w_rd_en, w_push})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
    end
  end

  // FIFO storage carries no reset; the pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= f7_rdata;
    end
  end

endmodule

// File: tb/tb_f7_rd_ctrl.sv
// Bench for f7_rd_ctrl: default instance (DEPTH=84, RD_LAT=2) plus a small
// instance (DEPTH=10, RD_LAT=1). The expected stream for a frame is the RAM
// image in address order; the last entry carries m_last.
module tb_f7_rd_ctrl;

  localparam int DEPTH  = 84;
  localparam int DW     = 16;
  localparam int AW     = 7;
  localparam int RD_LAT = 2;
  localparam int FD     = RD_LAT + 2;
  localparam int B_DEPTH = 10;
  localparam int B_LAT   = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- instance A ----------------
  logic          start, f7_rd_en, m_valid, m_last, m_ready, busy, done;
  logic [AW-1:0] f7_raddr;
  logic [DW-1:0] f7_rdata, m_data;
  logic [3:0]    dbg_state;

  f7_rd_ctrl #(.DEPTH(DEPTH), .DW(DW), .AW(AW), .RD_LAT(RD_LAT)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .f7_rd_en(f7_rd_en), .f7_raddr(f7_raddr), .f7_rdata(f7_rdata),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- instance B ----------------
  logic          start_b, f7_rd_en_b, m_valid_b, m_last_b, m_ready_b, busy_b, done_b;
  logic [AW-1:0] f7_raddr_b;
  logic [DW-1:0] f7_rdata_b, m_data_b;
  logic [3:0]    dbg_state_b;

  f7_rd_ctrl #(.DEPTH(B_DEPTH), .DW(DW), .AW(AW), .RD_LAT(B_LAT)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .f7_rd_en(f7_rd_en_b), .f7_raddr(f7_raddr_b), .f7_rdata(f7_rdata_b),
    .m_valid(m_valid_b), .m_data(m_data_b), .m_last(m_last_b), .m_ready(m_ready_b),
    .busy(busy_b), .done(done_b), .dbg_state(dbg_state_b)
  );

  // ---------------- RAM models ----------------
  logic [DW-1:0] ram_a [0:(1<<AW)-1];
  logic [DW-1:0] ram_b [0:(1<<AW)-1];

  logic [RD_LAT-1:0] pa_v = '0;
  logic [AW-1:0]     pa_a [0:RD_LAT-1];
  always @(posedge clk) begin
    pa_v[0] <= f7_rd_en;
    pa_a[0] <= f7_raddr;
    for (int i = 1; i < RD_LAT; i++) begin
      pa_v[i] <= pa_v[i-1];
      pa_a[i] <= pa_a[i-1];
    end
  end
  // Junk when no read is due, so a mistimed capture shows up as bad data.
  assign f7_rdata = pa_v[RD_LAT-1] ? ram_a[pa_a[RD_LAT-1]] : 16'hDEAD;

  logic          pb_v = 1'b0;
  logic [AW-1:0] pb_a;
  always @(posedge clk) begin
    pb_v <= f7_rd_en_b;
    pb_a <= f7_raddr_b;
  end
  assign f7_rdata_b = pb_v ? ram_b[pb_a] : 16'hBEEF;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rd_en"},   f7_rd_en, 0);
    check({tag, "_raddr"},   f7_raddr, 0);
    check({tag, "_m_valid"}, m_valid,  0);
    check({tag, "_m_data"},  m_data,   0);
    check({tag, "_m_last"},  m_last,   0);
    check({tag, "_busy"},    busy,     0);
    check({tag, "_done"},    done,     0);
  endtask

  // ---------------- scoreboard A ----------------
  logic [DW-1:0] exp_q[$];
  bit            in_frame, done_exp, prev_wait, hs, last_now;
  logic [DW-1:0] prev_data, first_data;
  logic          prev_last;
  int            reads, pops, start_cyc, first_valid_cyc, last_hs_cyc, done_cnt;

  always @(negedge clk) begin
    if (rst) begin
      check_quiet("rst");
      exp_q.delete();
      in_frame  = 0;
      done_exp  = 0;
      prev_wait = 0;
    end else begin
      check("state_onehot", $onehot(dbg_state), 1);
      check("busy", busy, in_frame);
      check("done", done, done_exp);
      if (done) done_cnt++;
      if (!in_frame) check("rd_outside_frame", f7_rd_en, 0);
      if (f7_rd_en) begin
        check("raddr", f7_raddr, reads);
        // reads issued minus beats taken = buffered + in flight
        check("credit", (reads - pops) < FD, 1);
        reads++;
      end
      if (prev_wait) begin
        check("hold_valid", m_valid, 1);
        check("hold_data",  m_data,  prev_data);
        check("hold_last",  m_last,  prev_last);
      end
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      hs       = m_valid && m_ready;
      last_now = 0;
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", hs, 0);
        end else begin
          check("data", m_data, exp_q[0]);
          check("last", m_last, exp_q.size() == 1);
          if (pops == 0) first_data = m_data;
          last_now = (exp_q.size() == 1);
          void'(exp_q.pop_front());
          pops++;
          if (last_now) last_hs_cyc = cyc;
        end
      end
      prev_wait = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      if (!in_frame && !done_exp && start) begin
        in_frame        = 1;
        reads           = 0;
        pops            = 0;
        start_cyc       = cyc;
        first_valid_cyc = -1;
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(ram_a[i]);
      end else if (last_now) begin
        in_frame = 0;
      end
      done_exp = last_now;
    end
  end

  // ---------------- scoreboard B ----------------
  logic [DW-1:0] exp_b[$];
  int b_beats = 0, b_start_cyc = 0, b_first_cyc = -1, b_last_cyc = 0;
  int b_done_cyc = 0, b_done_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (start_b) begin
        b_start_cyc = cyc;
        b_first_cyc = -1;
        b_beats     = 0;
        exp_b.delete();
        for (int i = 0; i < B_DEPTH; i++) exp_b.push_back(ram_b[i]);
      end
      if (m_valid_b && b_first_cyc < 0) b_first_cyc = cyc;
      if (m_valid_b && m_ready_b) begin
        b_beats++;
        if (exp_b.size() == 0) begin
          check("b_extra_beat", m_valid_b, 0);
        end else begin
          check("b_data", m_data_b, exp_b[0]);
          check("b_last", m_last_b, exp_b.size() == 1);
          if (exp_b.size() == 1) b_last_cyc = cyc;
          void'(exp_b.pop_front());
        end
      end
      if (done_b) begin
        b_done_cnt++;
        b_done_cyc = cyc;
      end
    end
  end

  // ---------------- drivers ----------------
  int ready_mode = 0;  // 0 always, 1 toggle, 2 random, 3 held low

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  task automatic fill_a(input bit rnd);
    for (int i = 0; i < (1 << AW); i++)
      ram_a[i] = rnd ? DW'($urandom) : DW'(i + 16'h100);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic set_ready(input int mode);
    ready_mode = mode;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base = done_cnt;
    int n = 0;
    while (done_cnt == base && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_done_seen"}, done_cnt != base, 1);
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_pops(input int target, input int budget);
    int n = 0;
    while (pops < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("pops_reached", pops >= target, 1);
  endtask

  // ---------------- main sequence ----------------
  int base_done;

  initial begin
    rst = 1'b1; start = 1'b0; start_b = 1'b0; m_ready_b = 1'b1;
    done_cnt = 0; reads = 0; pops = 0; first_valid_cyc = -1;
    fill_a(0);
    for (int i = 0; i < (1 << AW); i++) ram_b[i] = DW'($urandom);
    repeat (3) @(posedge clk);
    #2 check_quiet("reset");
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Straight frame, m_ready held high
    set_ready(0);
    base_done = done_cnt;
    pulse_start();
    wait_done("s1", 400);
    check("s1_first_latency", first_valid_cyc - start_cyc, RD_LAT + 2);
    check("s1_streaming", last_hs_cyc - first_valid_cyc, DEPTH - 1);
    check("s1_beats", pops, DEPTH);
    check("s1_reads", reads, DEPTH);
    check("s1_done_pulses", done_cnt - base_done, 1);

    // Alternating m_ready
    set_ready(1);
    pulse_start();
    wait_done("s2", 800);
    check("s2_beats", pops, DEPTH);

    // Backpressure: reads stop once the buffer and pipeline are full
    set_ready(3);
    pulse_start();
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("s3_reads_held", reads, FD);
    check("s3_valid_held", m_valid, 1);
    check("s3_data_held", m_data, 16'h100);
    ready_mode = 2;
    wait_done("s3", 1500);
    check("s3_beats", pops, DEPTH);

    // Second start mid-frame is ignored
    set_ready(0);
    base_done = done_cnt;
    pulse_start();
    wait_pops(40, 200);
    pulse_start();
    wait_done("s4", 400);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("s4_done_pulses", done_cnt - base_done, 1);
    check("s4_no_restart", busy, 0);

    // Reset mid-frame
    set_ready(2);
    pulse_start();
    wait_pops(30, 400);
    @(posedge clk); #1 rst = 1'b1;
    #1 check_quiet("async_rst");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("s5_no_autostart", busy, 0);
    check("s5_no_reads", f7_rd_en, 0);
    set_ready(0);
    pulse_start();
    wait_done("s5", 400);
    check("s5_restart_first", first_data, 16'h100);
    check("s5_beats", pops, DEPTH);

    // Randomised frames: random RAM image, random m_ready, random gaps
    for (int f = 0; f < 4; f++) begin
      fill_a(1);
      set_ready(2);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      pulse_start();
      wait_done("rand", 1500);
      check("rand_beats", pops, DEPTH);
    end

    // Small instance: DEPTH=10, RD_LAT=1, m_ready held high
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    for (int n = 0; n < 100 && b_done_cnt == 0; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("b_done_pulses", b_done_cnt, 1);
    check("b_beats", b_beats, B_DEPTH);
    check("b_first_latency", b_first_cyc - b_start_cyc, B_LAT + 2);
    check("b_done_after_last", b_done_cyc - b_last_cyc, 1);
    check("b_streaming", b_last_cyc - b_first_cyc, B_DEPTH - 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
